// File: rtl/stream_pkg.sv
// Shared types for the stream merger: beat payload, arbitration state, select-width helper.
package stream_pkg;

  localparam int BEAT_DW = 16;

  typedef struct packed {
    logic [BEAT_DW-1:0] data;
    logic               last;
  } beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Keeps a 1-bit select even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_merger_if.sv
// N input streams plus the merged output stream; slave is the merger's view, master the environment's.
interface stream_merger_if
  import stream_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = BEAT_DW
);
  localparam int SEL_WIDTH = sel_width(N);

  logic [N-1:0]           IN_VALID;
  logic [DATA_WIDTH-1:0]  IN_DATA [N];
  logic [N-1:0]           IN_LAST;
  logic [N-1:0]           IN_READY;
  logic                   OUT_VALID;
  logic [DATA_WIDTH-1:0]  OUT_DATA;
  logic [SEL_WIDTH-1:0]   OUT_SEL;
  logic                   OUT_LAST;
  logic                   OUT_READY;

  modport slave (
    input  IN_VALID, IN_DATA, IN_LAST, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_SEL, OUT_LAST
  );

  modport master (
    output IN_VALID, IN_DATA, IN_LAST, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_SEL, OUT_LAST
  );
endinterface

// File: rtl/stream_merger_rr_pick.sv
// Combinational rotating priority encoder: first requester after last_grant, wrapping modulo N.
module rr_pick #(
  parameter int N         = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [SEL_WIDTH-1:0] last_grant_i,
  output logic                 gnt_valid_o,
  output logic [SEL_WIDTH-1:0] gnt_idx_o
);

  // Scan farthest-first so the nearest requester is the last (winning) assignment.
  always_comb begin
    int idx;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % N;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = SEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_merger.sv
// N-to-1 packet-preserving stream merger: round-robin between packets, channel locked until LAST.
// One registered output stage; a beat accepted in cycle t is presented on OUT_* in cycle t+1.
module stream_merger
  import stream_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = BEAT_DW,
  localparam int SEL_WIDTH = sel_width(N)
) (
  input logic             CLK,
  input logic             RST,
  stream_merger_if.slave  bus
);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 out_vld_q, out_vld_d;
  beat_t                out_q, out_d;

  logic                 load_en;
  logic                 pick_vld;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 grant_vld;
  logic [SEL_WIDTH-1:0] cur_ch;
  logic [N-1:0]         rdy;
  logic                 accept;

  rr_pick #(
    .N         (N),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req_i        (bus.IN_VALID),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (pick_vld),
    .gnt_idx_o    (pick_idx)
  );

  assign load_en   = !out_vld_q || bus.OUT_READY;
  assign cur_ch    = (state_q == IDLE) ? pick_idx : lock_ch_q;
  assign grant_vld = (state_q == IDLE) ? pick_vld : 1'b1;

  // A locked channel keeps its ready even while it idles mid-packet, so others see bubbles.
  always_comb begin
    rdy = '0;
    if (grant_vld && load_en) rdy[cur_ch] = 1'b1;
  end

  assign accept = bus.IN_VALID[cur_ch] && rdy[cur_ch];

  always_comb begin
    state_d      = state_q;
    lock_ch_d    = lock_ch_q;
    last_grant_d = last_grant_q;
    out_vld_d    = out_vld_q;
    out_d        = out_q;
    sel_d        = sel_q;
    if (load_en) out_vld_d = accept;
    if (accept) begin
      out_d.data = bus.IN_DATA[cur_ch];
      out_d.last = bus.IN_LAST[cur_ch];
      sel_d      = cur_ch;
      if (bus.IN_LAST[cur_ch]) begin
        state_d      = IDLE;
        last_grant_d = cur_ch;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = cur_ch;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      lock_ch_q    <= '0;
      last_grant_q <= SEL_WIDTH'(N - 1);
      sel_q        <= '0;
      out_vld_q    <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      lock_ch_q    <= lock_ch_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      out_vld_q    <= out_vld_d;
      out_q        <= out_d;
    end
  end

  assign bus.IN_READY  = rdy;
  assign bus.OUT_VALID = out_vld_q;
  assign bus.OUT_DATA  = out_q.data;
  assign bus.OUT_LAST  = out_q.last;
  assign bus.OUT_SEL   = sel_q;

endmodule

// File: tb/tb_stream_merger.sv
// Directed bench for stream_merger: reset, single beat, round-robin, packet lock, backpressure, bubbles, reset mid-packet.
module tb_stream_merger;
  import stream_pkg::*;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;

  stream_merger_if #(.N(8), .DATA_WIDTH(16)) bus ();

  stream_merger #(.N(8), .DATA_WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    bus.IN_VALID = '0;
    bus.IN_LAST  = '0;
    for (int i = 0; i < 8; i++) bus.IN_DATA[i] = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    bus.OUT_READY = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.OUT_READY = 1'b1;
    RST = 1'b1;
    #2;
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", bus.OUT_VALID); end
    n_cmp++; if (bus.OUT_DATA !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", bus.OUT_DATA); end
    n_cmp++; if (bus.OUT_SEL !== 3'd0) begin n_err++; $display("FAIL reset_out_sel: got %0d want 0", bus.OUT_SEL); end
    n_cmp++; if (bus.OUT_LAST !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %0b want 0", bus.OUT_LAST); end
    n_cmp++; if (bus.IN_READY !== 8'h00) begin n_err++; $display("FAIL reset_in_ready: got %h want 00", bus.IN_READY); end
    do_reset();
  endtask

  task automatic test_single_beat();
    bus.IN_VALID   = 8'h04;
    bus.IN_DATA[2] = 16'hBEEF;
    bus.IN_LAST[2] = 1'b1;
    @(negedge CLK);
    n_cmp++; if (bus.IN_READY !== 8'h04) begin n_err++; $display("FAIL single_in_ready: got %h want 04", bus.IN_READY); end
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %0b want 1", bus.OUT_VALID); end
    n_cmp++; if (bus.OUT_DATA !== 16'hBEEF) begin n_err++; $display("FAIL single_out_data: got %h want beef", bus.OUT_DATA); end
    n_cmp++; if (bus.OUT_SEL !== 3'd2) begin n_err++; $display("FAIL single_out_sel: got %0d want 2", bus.OUT_SEL); end
    n_cmp++; if (bus.OUT_LAST !== 1'b1) begin n_err++; $display("FAIL single_out_last: got %0b want 1", bus.OUT_LAST); end
    @(negedge CLK);
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL single_drain: got %0b want 0", bus.OUT_VALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.IN_DATA[i] = 16'h1000 + 16'(i);
      bus.IN_LAST[i] = 1'b1;
    end
    bus.IN_VALID = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL rr_valid beat %0d: got %0b want 1", k, bus.OUT_VALID); end
      n_cmp++; if (bus.OUT_SEL !== 3'(k % 8)) begin n_err++; $display("FAIL rr_sel beat %0d: got %0d want %0d", k, bus.OUT_SEL, k % 8); end
      n_cmp++; if (bus.OUT_DATA !== 16'h1000 + 16'(k % 8)) begin n_err++; $display("FAIL rr_data beat %0d: got %h want %h", k, bus.OUT_DATA, 16'h1000 + 16'(k % 8)); end
    end
    idle_inputs();
    @(negedge CLK);
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %0b want 0", bus.OUT_VALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_packet_lock();
    do_reset();
    bus.IN_DATA[1] = 16'h1111;
    bus.IN_LAST[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.IN_DATA[3] = 16'h3000 + 16'(b);
      bus.IN_LAST[3] = (b == 3);
      bus.IN_VALID   = (b == 0) ? 8'h08 : 8'h0A;
      @(negedge CLK);
      n_cmp++; if (bus.IN_READY !== 8'h08) begin n_err++; $display("FAIL lock_in_ready beat %0d: got %h want 08", b, bus.IN_READY); end
      if (b > 0) begin
        n_cmp++; if (bus.OUT_SEL !== 3'd3) begin n_err++; $display("FAIL lock_sel beat %0d: got %0d want 3", b - 1, bus.OUT_SEL); end
        n_cmp++; if (bus.OUT_DATA !== 16'h3000 + 16'(b - 1)) begin n_err++; $display("FAIL lock_data beat %0d: got %h want %h", b - 1, bus.OUT_DATA, 16'h3000 + 16'(b - 1)); end
      end
      @(posedge CLK); #1;
    end
    bus.IN_VALID = 8'h02;
    @(negedge CLK);
    n_cmp++; if (bus.IN_READY !== 8'h02) begin n_err++; $display("FAIL lock_release_ready: got %h want 02", bus.IN_READY); end
    n_cmp++; if (bus.OUT_DATA !== 16'h3003 || bus.OUT_SEL !== 3'd3 || bus.OUT_LAST !== 1'b1) begin n_err++; $display("FAIL lock_last_beat: got %h/%0d/%0b want 3003/3/1", bus.OUT_DATA, bus.OUT_SEL, bus.OUT_LAST); end
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    n_cmp++; if (bus.OUT_SEL !== 3'd1 || bus.OUT_DATA !== 16'h1111) begin n_err++; $display("FAIL lock_next_grant: got %0d/%h want 1/1111", bus.OUT_SEL, bus.OUT_DATA); end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    int       src_idx;
    logic     acc;
    logic [15:0] exp_data;
    src_idx  = 0;
    acc      = 1'b0;
    exp_data = 16'h5000;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc > 0) begin
        @(posedge CLK); #1;
      end
      if (acc) src_idx++;
      bus.OUT_READY   = (cyc > 5);
      bus.IN_VALID    = (src_idx < 4) ? 8'h20 : 8'h00;
      bus.IN_DATA[5]  = 16'h5000 + 16'(src_idx);
      bus.IN_LAST[5]  = 1'b1;
      @(negedge CLK);
      if (cyc >= 1 && cyc <= 5) begin
        n_cmp++; if (bus.IN_READY !== 8'h00) begin n_err++; $display("FAIL bp_in_ready cyc %0d: got %h want 00", cyc, bus.IN_READY); end
        n_cmp++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 16'h5000 || bus.OUT_SEL !== 3'd5) begin n_err++; $display("FAIL bp_hold cyc %0d: got %0b/%h/%0d want 1/5000/5", cyc, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL); end
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        n_cmp++; if (bus.OUT_DATA !== exp_data || bus.OUT_SEL !== 3'd5) begin n_err++; $display("FAIL bp_order: got %h/%0d want %h/5", bus.OUT_DATA, bus.OUT_SEL, exp_data); end
        exp_data++;
      end
      acc = bus.IN_READY[5] && bus.IN_VALID[5];
    end
    n_cmp++; if (exp_data !== 16'h5004) begin n_err++; $display("FAIL bp_count: got %h want 5004", exp_data); end
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_mid_packet_bubble();
    int   b6;
    int   n6;
    int   n0;
    logic last6;
    logic acc;
    b6 = 0; n6 = 0; n0 = 0; last6 = 1'b0; acc = 1'b0;
    bus.OUT_READY  = 1'b1;
    bus.IN_DATA[0] = 16'h0A0A;
    bus.IN_LAST[0] = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc > 0) begin
        @(posedge CLK); #1;
      end
      if (acc) b6++;
      bus.IN_VALID[6] = (b6 < 4) && !(cyc >= 2 && cyc <= 4);
      bus.IN_DATA[6]  = 16'h6000 + 16'(b6);
      bus.IN_LAST[6]  = (b6 == 3);
      bus.IN_VALID[0] = (cyc <= 7);
      @(negedge CLK);
      if (cyc <= 6) begin
        n_cmp++; if (bus.IN_READY !== 8'h40) begin n_err++; $display("FAIL bubble_ready cyc %0d: got %h want 40", cyc, bus.IN_READY); end
      end
      if (cyc == 7) begin
        n_cmp++; if (bus.IN_READY !== 8'h01) begin n_err++; $display("FAIL bubble_release: got %h want 01", bus.IN_READY); end
      end
      if (bus.OUT_VALID) begin
        if (bus.OUT_SEL == 3'd6) begin
          n_cmp++; if (bus.OUT_DATA !== 16'h6000 + 16'(n6)) begin n_err++; $display("FAIL bubble_ch6_data: got %h want %h", bus.OUT_DATA, 16'h6000 + 16'(n6)); end
          n6++;
          if (bus.OUT_LAST) last6 = 1'b1;
        end else begin
          n_cmp++; if (last6 !== 1'b1 || bus.OUT_SEL !== 3'd0) begin n_err++; $display("FAIL bubble_interleave: got sel %0d last6 %0b want sel 0 after last", bus.OUT_SEL, last6); end
          n0++;
        end
      end
      acc = bus.IN_READY[6] && bus.IN_VALID[6];
    end
    n_cmp++; if (n6 !== 4 || n0 !== 1) begin n_err++; $display("FAIL bubble_counts: got %0d/%0d want 4/1", n6, n0); end
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_packet();
    bus.OUT_READY  = 1'b1;
    bus.IN_VALID   = 8'h10;
    bus.IN_DATA[4] = 16'h4000;
    bus.IN_LAST[4] = 1'b0;
    @(negedge CLK);
    n_cmp++; if (bus.IN_READY !== 8'h10) begin n_err++; $display("FAIL rstmid_first_ready: got %h want 10", bus.IN_READY); end
    @(posedge CLK); #1;
    bus.OUT_READY  = 1'b0;
    bus.IN_DATA[4] = 16'h4001;
    @(negedge CLK);
    n_cmp++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_SEL !== 3'd4) begin n_err++; $display("FAIL rstmid_locked: got %0b/%0d want 1/4", bus.OUT_VALID, bus.OUT_SEL); end
    #1;
    RST = 1'b1;
    #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_async_valid: got %0b want 0", bus.OUT_VALID); end
    n_cmp++; if (bus.OUT_DATA !== 16'h0 || bus.OUT_SEL !== 3'd0) begin n_err++; $display("FAIL rstmid_async_out: got %h/%0d want 0000/0", bus.OUT_DATA, bus.OUT_SEL); end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    bus.OUT_READY  = 1'b1;
    bus.IN_VALID   = 8'h11;
    bus.IN_DATA[0] = 16'h0A00;
    bus.IN_LAST[0] = 1'b1;
    bus.IN_DATA[4] = 16'h4444;
    bus.IN_LAST[4] = 1'b1;
    #1;
    n_cmp++; if (bus.IN_READY !== 8'h01) begin n_err++; $display("FAIL rstmid_ch0_first: got %h want 01", bus.IN_READY); end
    @(posedge CLK); #1;
    bus.IN_VALID = 8'h10;
    #1;
    n_cmp++; if (bus.OUT_SEL !== 3'd0 || bus.OUT_DATA !== 16'h0A00) begin n_err++; $display("FAIL rstmid_ch0_out: got %0d/%h want 0/0a00", bus.OUT_SEL, bus.OUT_DATA); end
    n_cmp++; if (bus.IN_READY !== 8'h10) begin n_err++; $display("FAIL rstmid_ch4_next: got %h want 10", bus.IN_READY); end
    @(posedge CLK); #1;
    idle_inputs();
    n_cmp++; if (bus.OUT_SEL !== 3'd4 || bus.OUT_DATA !== 16'h4444) begin n_err++; $display("FAIL rstmid_ch4_out: got %0d/%h want 4/4444", bus.OUT_SEL, bus.OUT_DATA); end
    @(posedge CLK); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST   = 1'b1;
    test_reset();
    test_single_beat();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_mid_packet_bubble();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
